// File: rtl/fpu_wb_sched.sv
// fpu_wb_sched: FPU writeback-port scheduler; define FPU_WB_PENDING_EN to build the pending_rd scoreboard
module fpu_wb_sched #(
   parameter int MAXLAT     = 16,
   parameter int LAT_FADD   = 4,
   parameter int LAT_FSUB   = 4,
   parameter int LAT_FDIV   = 10,
   parameter int LAT_FSQRT  = 8,
   parameter int LAT_FCVTWS = 3,
   parameter int LAT_FCVTSW = 3,
   parameter int LAT_FMUL   = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue_valid,
   input  logic [2:0]   issue_op,
   input  logic [4:0]   issue_rd,
   output logic         issue_ready,
   input  logic         flush,
   input  logic [223:0] fpu_results,
   output logic         wb_valid,
   output logic [4:0]   wb_rd,
   output logic [31:0]  wb_data,
   output logic         busy,
   output logic [31:0]  pending_rd
);
   logic [MAXLAT-1:0] v_q, v_d;
   logic [2:0]        op_q [MAXLAT];
   logic [2:0]        op_d [MAXLAT];
   logic [4:0]        rd_q [MAXLAT];
   logic [4:0]        rd_d [MAXLAT];
   int                lat;
   logic              acc;

   // latency of the presented op (0 = no slot) and writeback-port collision check
   always_comb begin
      lat = issue_op == 3'd0 ? LAT_FADD :
            issue_op == 3'd1 ? LAT_FSUB :
            issue_op == 3'd2 ? LAT_FDIV :
            issue_op == 3'd3 ? LAT_FSQRT :
            issue_op == 3'd4 ? LAT_FCVTWS :
            issue_op == 3'd5 ? LAT_FCVTSW :
            issue_op == 3'd6 ? LAT_FMUL : 0;
      issue_ready = 1'b1;
      for (int i = 1; i < MAXLAT; i++)
         if (i == lat && v_q[i]) issue_ready = 1'b0;
   end

   assign acc = issue_valid & issue_ready & (lat != 0);

   // shift slots toward writeback; an accepted issue lands in slot lat-1
   always_comb begin
      v_d = {1'b0, v_q[MAXLAT-1:1]};
      for (int i = 0; i < MAXLAT - 1; i++) begin
         op_d[i] = op_q[i+1];
         rd_d[i] = rd_q[i+1];
      end
      op_d[MAXLAT-1] = '0;
      rd_d[MAXLAT-1] = '0;
      for (int i = 0; i < MAXLAT; i++)
         if (acc && lat == i + 1) begin
            v_d[i]  = 1'b1;
            op_d[i] = issue_op;
            rd_d[i] = issue_rd;
         end
   end

   // slot register; reset and flush empty every slot and drop the same-cycle issue
   always_ff @(posedge clk) begin
      v_q  <= (rst || flush) ? '0 : v_d;
      op_q <= op_d;
      rd_q <= rd_d;
   end

   // writeback from slot 0, result picked by the unit that owns it
   always_comb begin
      wb_valid = v_q[0];
      wb_rd    = v_q[0] ? rd_q[0] : '0;
      wb_data  = '0;
      for (int k = 0; k < 7; k++)
         if (v_q[0] && op_q[0] == 3'(k)) wb_data = fpu_results[32*k +: 32];
   end

   assign busy = |v_q;

`ifdef FPU_WB_PENDING_EN
   // destination registers still owed a writeback; x0 is never tracked
   always_comb begin
      pending_rd = '0;
      for (int i = 0; i < MAXLAT; i++)
         if (v_q[i] && rd_q[i] != 5'd0) pending_rd[rd_q[i]] = 1'b1;
   end
`else
   assign pending_rd = '0;
`endif
endmodule

// File: tb/tb_fpu_wb_sched.sv
// tb_fpu_wb_sched: scoreboard bench for fpu_wb_sched
module tb_fpu_wb_sched;
   logic         clk = 0, rst = 1, issue_valid = 0, flush = 0;
   logic [2:0]   issue_op = 3'd7;
   logic [4:0]   issue_rd = '0;
   logic [223:0] fpu_results;
   logic         issue_ready, wb_valid, busy;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data, pending_rd;
   int           cyc = 0, n_chk = 0, n_pass = 0;
   bit           mon_en = 0, ov_en = 0;
   typedef struct {logic [4:0] rd; logic [31:0] data; int c;} exp_t;
   exp_t         sb[$];
   exp_t         m_e;

   fpu_wb_sched dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_rd(issue_rd), .issue_ready(issue_ready), .flush(flush),
      .fpu_results(fpu_results), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .busy(busy), .pending_rd(pending_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] res(int k, int c);
      return {8'(k), 8'hC3, 16'(c)};
   endfunction

   always_comb begin
      for (int k = 0; k < 7; k++)
         fpu_results[32*k +: 32] = (k == 0 && ov_en) ? 32'h3F800000 : res(k, cyc);
   end

   task automatic check(input bit ok, input string msg);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s", msg);
   endtask

   task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input int c);
      exp_t e;
      int i = 0;
      e.rd = rd; e.data = data; e.c = c;
      while (i < sb.size() && sb[i].c <= c) i++;
      sb.insert(i, e);
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rd);
      issue_valid = v; issue_op = op; issue_rd = rd;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      drive(0, 3'd7, 5'd0);
      repeat (n) tick;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (wb_valid) begin
            if (sb.size() == 0)
               check(0, $sformatf("unexpected_wb cyc=%0d got rd=%0d data=%h required no writeback", cyc, wb_rd, wb_data));
            else begin
               m_e = sb.pop_front();
               check(wb_rd == m_e.rd && wb_data == m_e.data && cyc == m_e.c,
                     $sformatf("wb got rd=%0d data=%h cyc=%0d required rd=%0d data=%h cyc=%0d",
                               wb_rd, wb_data, cyc, m_e.rd, m_e.data, m_e.c));
            end
         end else
            check(wb_rd == 0 && wb_data == 0,
                  $sformatf("idle_zero cyc=%0d got rd=%0d data=%h required 0/0", cyc, wb_rd, wb_data));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      repeat (2) tick;
      check(!wb_valid && !busy && pending_rd == 0, $sformatf("reset_state got v=%b busy=%b pend=%h required 0/0/0", wb_valid, busy, pending_rd));
      drive(1, 3'd0, 5'd5);
      #1 check(issue_ready, $sformatf("ready_in_reset got %b required 1", issue_ready));
      tick;
      check(!busy, $sformatf("issue_ignored_in_reset busy got %b required 0", busy));
      rst = 0;
      mon_en = 1;
      idle(1);
      // single fadd
      c = cyc; ov_en = 1;
      drive(1, 3'd0, 5'd5);
      #1 check(issue_ready, $sformatf("fadd_ready got %b required 1", issue_ready));
      expect_wb(5'd5, 32'h3F800000, c + 4);
      tick; idle(6); ov_en = 0;
      // fdiv then colliding fsqrt
      c = cyc;
      drive(1, 3'd2, 5'd1);
      expect_wb(5'd1, res(2, c + 10), c + 10);
      tick; idle(1);
      drive(1, 3'd3, 5'd2);
      #1 check(!issue_ready, $sformatf("fsqrt_collision got ready=%b required 0", issue_ready));
      tick;
      drive(1, 3'd3, 5'd2);
      #1 check(issue_ready, $sformatf("fsqrt_retry got ready=%b required 1", issue_ready));
      expect_wb(5'd2, res(3, c + 11), c + 11);
      tick; idle(10);
      // back-to-back fmul
      c = cyc;
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'd6, 5'(i + 1));
         #1 check(issue_ready, $sformatf("fmul_stream_ready[%0d] got %b required 1", i, issue_ready));
         expect_wb(5'(i + 1), res(6, c + i + 3), c + i + 3);
         tick;
      end
      idle(2);
      check(busy, $sformatf("busy_last_wb got %b required 1", busy));
      tick;
      check(!busy, $sformatf("busy_after_stream got %b required 0", busy));
      idle(2);
      // flush kills fdiv and a same-cycle issue
      drive(1, 3'd2, 5'd7);
      tick; idle(3);
      check(busy, $sformatf("busy_before_flush got %b required 1", busy));
      flush = 1;
      drive(1, 3'd6, 5'd3);
      tick;
      flush = 0;
      drive(0, 3'd7, 5'd0);
      check(!busy, $sformatf("busy_after_flush got %b required 0", busy));
      idle(8);
      // short op overtakes long op
      c = cyc;
      drive(1, 3'd2, 5'd10);
      expect_wb(5'd10, res(2, c + 10), c + 10);
      tick;
      drive(1, 3'd6, 5'd11);
      expect_wb(5'd11, res(6, c + 4), c + 4);
      tick; idle(10);
      // pending register mask
      c = cyc;
      drive(1, 3'd4, 5'd9);
      expect_wb(5'd9, res(4, c + 3), c + 3);
      tick;
      drive(0, 3'd7, 5'd0);
`ifdef FPU_WB_PENDING_EN
      for (int i = 1; i <= 3; i++) begin
         check(pending_rd == 32'h200, $sformatf("pending_rd9 cyc+%0d got %h required 00000200", i, pending_rd));
         tick;
      end
      check(pending_rd == 0, $sformatf("pending_clear got %h required 0", pending_rd));
`else
      check(pending_rd == 0, $sformatf("pending_tied got %h required 0", pending_rd));
      idle(3);
`endif
      c = cyc;
      drive(1, 3'd5, 5'd0);
      expect_wb(5'd0, res(5, c + 3), c + 3);
      tick;
      drive(0, 3'd7, 5'd0);
      check(pending_rd == 0, $sformatf("pending_rd0 got %h required 0", pending_rd));
      idle(5);
      // reset with ops in flight
      drive(1, 3'd2, 5'd1); tick;
      drive(1, 3'd3, 5'd2); tick;
      drive(1, 3'd0, 5'd3); tick;
      check(busy, $sformatf("busy_before_reset got %b required 1", busy));
      rst = 1;
      drive(1, 3'd6, 5'd4);
      tick;
      check(issue_ready && !busy, $sformatf("reset_midop got ready=%b busy=%b required 1/0", issue_ready, busy));
      tick;
      rst = 0;
      idle(12);
      check(sb.size() == 0, $sformatf("scoreboard_drained got %0d left required 0", sb.size()));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
